// File: rtl/char_action_sequencer.sv
// rtl/char_action_sequencer.sv - per-player action FSM: buttons to 4-bit character state, frame-timed attack phases
// Advances only on accepted frame ticks; attack requests are edge-captured every clk.
module char_action_sequencer #(
  parameter int ATK_START_FRAMES    = 5,
  parameter int ATK_ACTIVE_FRAMES   = 2,
  parameter int ATK_RECOVERY_FRAMES = 16,
  parameter int DIR_START_FRAMES    = 4,
  parameter int DIR_ACTIVE_FRAMES   = 3,
  parameter int DIR_RECOVERY_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  output logic [3:0] state,
  output logic [4:0] frame_cnt,
  output logic       attack_active,
  output logic       busy,
  output logic       state_upd
);

  typedef enum logic [3:0] {
    S_IDLE                = 4'd0,
    S_LEFT                = 4'd1,
    S_RIGHT               = 4'd2,
    S_ATTACK_START        = 4'd3,
    S_ATTACK_ACTIVE       = 4'd4,
    S_ATTACK_RECOVERY     = 4'd5,
    S_ATTACK_DIR_START    = 4'd6,
    S_ATTACK_DIR_ACTIVE   = 4'd7,
    S_ATTACK_DIR_RECOVERY = 4'd8
  } state_t;

  localparam logic [4:0] AS_LAST = 5'(ATK_START_FRAMES - 1);
  localparam logic [4:0] AA_LAST = 5'(ATK_ACTIVE_FRAMES - 1);
  localparam logic [4:0] AR_LAST = 5'(ATK_RECOVERY_FRAMES - 1);
  localparam logic [4:0] DS_LAST = 5'(DIR_START_FRAMES - 1);
  localparam logic [4:0] DA_LAST = 5'(DIR_ACTIVE_FRAMES - 1);
  localparam logic [4:0] DR_LAST = 5'(DIR_RECOVERY_FRAMES - 1);

  state_t     cur;
  state_t     nxt;
  state_t     phase_next;
  logic [4:0] phase_last;
  logic [4:0] cnt_nxt;
  logic       atk_q;
  logic       attack_pend;
  logic       pend_nxt;
  logic       atk_edge;
  logic       tick_ok;
  logic       move_state;
  logic       pend_eff;

  assign atk_edge   = btn_attack & ~atk_q;
  assign tick_ok    = frame_tick & ~freeze;
  assign move_state = (cur == S_IDLE) || (cur == S_LEFT) || (cur == S_RIGHT);
  // An edge in the same clk as the tick already counts toward that tick's decision.
  assign pend_eff   = attack_pend | (atk_edge & move_state);

  always_comb begin
    phase_last = '0;
    phase_next = S_IDLE;
    case (cur)
      S_ATTACK_START:        begin phase_last = AS_LAST; phase_next = S_ATTACK_ACTIVE;       end
      S_ATTACK_ACTIVE:       begin phase_last = AA_LAST; phase_next = S_ATTACK_RECOVERY;     end
      S_ATTACK_RECOVERY:     begin phase_last = AR_LAST; phase_next = S_IDLE;                end
      S_ATTACK_DIR_START:    begin phase_last = DS_LAST; phase_next = S_ATTACK_DIR_ACTIVE;   end
      S_ATTACK_DIR_ACTIVE:   begin phase_last = DA_LAST; phase_next = S_ATTACK_DIR_RECOVERY; end
      S_ATTACK_DIR_RECOVERY: begin phase_last = DR_LAST; phase_next = S_IDLE;                end
      default: ;
    endcase
  end

  always_comb begin
    nxt      = cur;
    cnt_nxt  = frame_cnt;
    pend_nxt = freeze ? 1'b0 : pend_eff;
    if (tick_ok) begin
      case (cur)
        S_IDLE, S_LEFT, S_RIGHT: begin
          cnt_nxt  = '0;
          pend_nxt = 1'b0;
          if (pend_eff)
            nxt = (btn_left ^ btn_right) ? S_ATTACK_DIR_START : S_ATTACK_START;
          else if (btn_left & ~btn_right)
            nxt = S_LEFT;
          else if (btn_right & ~btn_left)
            nxt = S_RIGHT;
          else
            nxt = S_IDLE;
        end
        S_ATTACK_START, S_ATTACK_ACTIVE, S_ATTACK_RECOVERY,
        S_ATTACK_DIR_START, S_ATTACK_DIR_ACTIVE, S_ATTACK_DIR_RECOVERY: begin
          if (frame_cnt == phase_last) begin
            nxt     = phase_next;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = frame_cnt + 5'd1;
          end
        end
        default: begin
          nxt     = S_IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur         <= S_IDLE;
      frame_cnt   <= '0;
      attack_pend <= 1'b0;
      atk_q       <= 1'b0;
      state_upd   <= 1'b0;
    end else begin
      cur         <= nxt;
      frame_cnt   <= cnt_nxt;
      attack_pend <= pend_nxt;
      atk_q       <= btn_attack;
      state_upd   <= tick_ok;
    end
  end

  assign state         = cur;
  assign busy          = (cur >= S_ATTACK_START) && (cur <= S_ATTACK_DIR_RECOVERY);
  assign attack_active = (cur == S_ATTACK_ACTIVE) || (cur == S_ATTACK_DIR_ACTIVE);

endmodule

// File: tb/tb_char_action_sequencer.sv
// tb/tb_char_action_sequencer.sv - self-checking bench for char_action_sequencer
module tb_char_action_sequencer;
  localparam int AS = 5, AA = 2, AR = 16, DS = 4, DA = 3, DR = 15;

  logic       clk = 0, rst = 0, frame_tick = 0, freeze = 0;
  logic       btn_left = 0, btn_right = 0, btn_attack = 0;
  logic [3:0] state;
  logic [4:0] frame_cnt;
  logic       attack_active, busy, state_upd;

  int n_checks = 0, n_pass = 0, upd_count = 0;
  int n0, n3, n4, n5;

  // Model: an attack is "elapsed ticks since it began"; phase is derived arithmetically.
  bit m_att, m_dir, m_pend, m_prev, m_upd;
  int m_el, m_move;

  char_action_sequencer #(
    .ATK_START_FRAMES(AS), .ATK_ACTIVE_FRAMES(AA), .ATK_RECOVERY_FRAMES(AR),
    .DIR_START_FRAMES(DS), .DIR_ACTIVE_FRAMES(DA), .DIR_RECOVERY_FRAMES(DR)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .freeze(freeze),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .state(state), .frame_cnt(frame_cnt), .attack_active(attack_active),
    .busy(busy), .state_upd(state_upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_att = 0; m_dir = 0; m_pend = 0; m_prev = 0; m_upd = 0; m_el = 0; m_move = 0;
  endtask

  task automatic model_update(input logic t, f, l, r, a);
    bit e, acc, pe;
    e = a & ~m_prev;
    m_prev = a;
    acc = t & ~f;
    m_upd = acc;
    if (!m_att) begin
      pe = m_pend | e;
      if (f) m_pend = 0;
      else if (acc) begin
        m_pend = 0;
        if (pe) begin
          m_att = 1; m_dir = l ^ r; m_el = 0;
        end else begin
          m_move = (l && !r) ? 1 : (r && !l) ? 2 : 0;
        end
      end else m_pend = pe;
    end else if (acc) begin
      m_el++;
      if (m_el == (m_dir ? DS + DA + DR : AS + AA + AR)) begin
        m_att = 0; m_move = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int s, c, base, l1, l2;
    if (m_att) begin
      base = m_dir ? 6 : 3;
      l1 = m_dir ? DS : AS;
      l2 = m_dir ? DA : AA;
      if (m_el < l1) begin s = base; c = m_el; end
      else if (m_el < l1 + l2) begin s = base + 1; c = m_el - l1; end
      else begin s = base + 2; c = m_el - l1 - l2; end
    end else begin
      s = m_move; c = 0;
    end
    chk({tag, ".state"}, 32'(state), s);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), c);
    chk({tag, ".busy"}, 32'(busy), (s >= 3 && s <= 8) ? 1 : 0);
    chk({tag, ".attack_active"}, 32'(attack_active), (s == 4 || s == 7) ? 1 : 0);
    chk({tag, ".state_upd"}, 32'(state_upd), 32'(m_upd));
  endtask

  task automatic step(input string tag, input logic t, f, l, r, a);
    frame_tick = t; freeze = f; btn_left = l; btn_right = r; btn_attack = a;
    @(posedge clk);
    if (rst) model_update(t, f, l, r, a);
    else m_reset();
    @(negedge clk);
    if (state_upd) upd_count++;
    check_outputs(tag);
  endtask

  task automatic frame(input string tag, input logic f, l, r, a);
    step(tag, 1, f, l, r, a);
    step(tag, 0, f, l, r, a);
    step(tag, 0, f, l, r, a);
  endtask

  initial begin
    bit rf, rl, rr, ra;
    m_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1;

    // Movement
    frame("mv", 0, 0, 1, 0);
    chk("move_right", 32'(state), 2);
    repeat (3) frame("mv", 0, 0, 1, 0);
    frame("mv", 0, 1, 1, 0);
    chk("move_both", 32'(state), 0);
    frame("mv", 0, 1, 0, 0);
    chk("move_left", 32'(state), 1);
    frame("mv", 0, 0, 0, 0);

    // Neutral attack
    step("na", 0, 0, 0, 0, 1);
    step("na", 0, 0, 0, 0, 0);
    n0 = 0; n3 = 0; n4 = 0; n5 = 0;
    for (int i = 0; i < 24; i++) begin
      frame("na", 0, 0, 0, 0);
      case (state)
        4'd0: n0++;
        4'd3: n3++;
        4'd4: n4++;
        4'd5: n5++;
        default: ;
      endcase
    end
    chk("na_start_ticks", n3, 5);
    chk("na_active_ticks", n4, 2);
    chk("na_recov_ticks", n5, 16);
    chk("na_idle_end", 32'(state), 0);

    // Directional attack with left held
    frame("da", 0, 1, 0, 0);
    step("da", 0, 0, 1, 0, 1);
    for (int i = 0; i < 22; i++) frame("da", 0, 1, 0, 0);
    chk("da_last_recov", 32'(state), 8);
    frame("da", 0, 1, 0, 0);
    chk("da_idle", 32'(state), 0);
    frame("da", 0, 1, 0, 0);
    chk("da_resume_left", 32'(state), 1);

    // Held attack button never retriggers
    frame("hold", 0, 0, 0, 0);
    step("hold", 0, 0, 0, 0, 1);
    for (int i = 0; i < 26; i++) frame("hold", 0, 0, 0, 1);
    chk("hold_no_retrigger", 32'(state), 0);

    // Edge during recovery is dropped
    step("rec", 0, 0, 0, 0, 0);
    step("rec", 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) frame("rec", 0, 0, 0, 1);
    chk("rec_in_recovery", 32'(state), 5);
    step("rec", 0, 0, 0, 0, 0);
    step("rec", 0, 0, 0, 0, 1);
    step("rec", 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) frame("rec", 0, 0, 0, 0);
    chk("rec_edge_dropped", 32'(state), 0);

    // Freeze during ATTACK_START at frame_cnt=2
    step("fz", 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) frame("fz", 0, 0, 0, 0);
    chk("fz_cnt_before", 32'(frame_cnt), 2);
    upd_count = 0;
    frame("fz", 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) frame("fz", 1, 0, 0, 0);
    chk("fz_state_held", 32'(state), 3);
    chk("fz_cnt_held", 32'(frame_cnt), 2);
    chk("fz_no_upd", upd_count, 0);
    for (int i = 0; i < 2; i++) frame("fz", 0, 0, 0, 0);
    chk("fz_resume_cnt", 32'(frame_cnt), 4);
    frame("fz", 0, 0, 0, 0);
    chk("fz_to_active", 32'(state), 4);
    for (int i = 0; i < 18; i++) frame("fz", 0, 0, 0, 0);
    chk("fz_done", 32'(state), 0);

    // Edge captured while frozen in IDLE is discarded
    step("fzi", 0, 1, 0, 0, 1);
    step("fzi", 0, 0, 0, 0, 1);
    frame("fzi", 0, 0, 0, 1);
    chk("fz_idle_edge_discard", 32'(state), 0);

    // Reset mid ATTACK_ACTIVE
    step("rs", 0, 0, 0, 0, 0);
    step("rs", 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) frame("rs", 0, 0, 0, 0);
    chk("rs_pre_active", 32'(state), 4);
    #2 rst = 0;
    #1;
    m_reset();
    chk("rs_async_state", 32'(state), 0);
    chk("rs_async_busy", 32'(busy), 0);
    chk("rs_async_active", 32'(attack_active), 0);
    chk("rs_async_cnt", 32'(frame_cnt), 0);
    step("rs_hold", 1, 0, 0, 1, 0);
    rst = 1;
    upd_count = 0;
    for (int i = 0; i < 3; i++) frame("rs_post", 0, 0, 0, 0);
    chk("rs_post_upd", upd_count, 3);
    chk("rs_post_state", 32'(state), 0);

    // Randomized traffic against the model
    rf = 0; rl = 0; rr = 0; ra = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) rf = ~rf;
      if ($urandom_range(19) == 0) rl = ~rl;
      if ($urandom_range(19) == 0) rr = ~rr;
      if ($urandom_range(7) == 0)  ra = ~ra;
      step("rnd", ($urandom_range(3) == 0), rf, rl, rr, ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
